// File: rtl/coin_dispenser.sv
// Coin refund dispenser: greedy largest-coin selection from four hopper stocks,
// one eject pulse per coin spaced three cycles apart, with shortfall reporting.
module coin_dispenser (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       Return,
    input  logic [6:0] Amount,
    input  logic       Load,
    input  logic [3:0] Stock50,
    input  logic [3:0] Stock100,
    input  logic [3:0] Stock500,
    input  logic [3:0] Stock1000,
    output logic       Return50,
    output logic       Return100,
    output logic       Return500,
    output logic       Return1000,
    output logic       Busy,
    output logic       Done,
    output logic       Short,
    output logic [6:0] Leftover
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t           r_state;
    state_t           w_next;

    // Index 0..3 = 50, 100, 500, 1000 won.
    logic [3:0][3:0]  r_stock;
    logic [6:0]       r_remain;
    logic [1:0]       r_sel;
    logic             r_short;
    logic [6:0]       r_leftover;

    logic [3:0]       r_ret;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_pick;
    logic             w_pick_ok;
    logic             w_accept;
    logic [3:0]       w_ret_d;
    logic             w_busy_d;
    logic             w_done_d;

    function automatic logic [6:0] coin_val(input logic [1:0] idx);
        case (idx)
            2'd0:    coin_val = 7'd1;
            2'd1:    coin_val = 7'd2;
            2'd2:    coin_val = 7'd10;
            default: coin_val = 7'd20;
        endcase
    endfunction

    // Ascending scan: the last eligible hit is the largest denomination.
    always_comb begin
        w_pick    = '0;
        w_pick_ok = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_stock[i] != '0 && coin_val(2'(i)) <= r_remain) begin
                w_pick    = 2'(i);
                w_pick_ok = 1'b1;
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && Return && !Load;

    // State and registered outputs; outputs are precomputed from the next state
    // so every output lines up with the state it belongs to.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_ret   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = S_SELECT;
            end
            S_SELECT: begin
                if (r_remain == '0 || !w_pick_ok)
                    w_next = S_FINISH;
                else
                    w_next = S_PULSE;
            end
            S_PULSE:  w_next = S_GAP;
            S_GAP:    w_next = S_SELECT;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ret_d  = '0;
        w_busy_d = (w_next != S_IDLE);
        w_done_d = (w_next == S_FINISH);
        if (w_next == S_PULSE)
            w_ret_d[w_pick] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stock    <= '0;
            r_remain   <= '0;
            r_sel      <= '0;
            r_short    <= 1'b0;
            r_leftover <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Load) begin
                        r_stock <= {Stock1000, Stock500, Stock100, Stock50};
                    end else if (Return) begin
                        r_remain   <= Amount;
                        r_short    <= 1'b0;
                        r_leftover <= '0;
                    end
                end
                S_SELECT: begin
                    if (w_pick_ok)
                        r_sel <= w_pick;
                    if (r_remain != '0 && !w_pick_ok)
                        r_short <= 1'b1;
                    if (w_next == S_FINISH)
                        r_leftover <= r_remain;
                end
                S_PULSE: begin
                    r_remain       <= r_remain - coin_val(r_sel);
                    r_stock[r_sel] <= r_stock[r_sel] - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign Return50   = r_ret[0];
    assign Return100  = r_ret[1];
    assign Return500  = r_ret[2];
    assign Return1000 = r_ret[3];
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Short      = r_short;
    assign Leftover   = r_leftover;

endmodule
